// File: rtl/alu_pkg.sv
// Shared constants for the lab CPU ALU: default widths and the 16 opcode encodings.
package alu_pkg;

   localparam int DEFAULT_DATA_WIDTH   = 8;
   localparam int DEFAULT_OPCODE_WIDTH = 4;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_INC = 4'd2;
   localparam logic [3:0] OP_DEC = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;
   localparam logic [3:0] OP_NOT = 4'd7;
   localparam logic [3:0] OP_SHL = 4'd8;
   localparam logic [3:0] OP_SHR = 4'd9;
   localparam logic [3:0] OP_SAR = 4'd10;
   localparam logic [3:0] OP_ROL = 4'd11;
   localparam logic [3:0] OP_ROR = 4'd12;
   localparam logic [3:0] OP_NEG = 4'd13;
   localparam logic [3:0] OP_ADC = 4'd14;
   localparam logic [3:0] OP_SBB = 4'd15;

endpackage

// File: rtl/alu_datapath.sv
// Combinational ALU core: one shared adder and one shared subtractor at
// DATA_WIDTH+1 bits, with INC/DEC/NEG/ADC/SBB expressed as operand tweaks.
module alu_datapath
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int OPCODE_WIDTH = DEFAULT_OPCODE_WIDTH
) (
   input  logic [DATA_WIDTH-1:0]   a,
   input  logic [DATA_WIDTH-1:0]   b,
   input  logic [OPCODE_WIDTH-1:0] opcode,
   input  logic                    carry_in,
   output logic [DATA_WIDTH-1:0]   result,
   output logic                    carry_out,
   output logic                    overflow
);

   localparam int MSB = DATA_WIDTH - 1;

   logic [DATA_WIDTH-1:0] add_b;
   logic [DATA_WIDTH-1:0] sub_a;
   logic [DATA_WIDTH-1:0] sub_b;
   logic                  add_cin;
   logic                  sub_bin;
   logic [DATA_WIDTH:0]   add_sum;
   logic [DATA_WIDTH:0]   sub_diff;
   logic                  add_v;
   logic                  sub_v;

   // Bit DATA_WIDTH of the difference is the borrow, so C for SUB/DEC/NEG/SBB falls out directly.
   always_comb begin
      add_b   = b;
      add_cin = 1'b0;
      sub_a   = a;
      sub_b   = b;
      sub_bin = 1'b0;
      case (opcode)
         OP_INC:  add_b = DATA_WIDTH'(1);
         OP_ADC:  add_cin = carry_in;
         OP_DEC:  sub_b = DATA_WIDTH'(1);
         OP_NEG:  begin
            sub_a = '0;
            sub_b = a;
         end
         OP_SBB:  sub_bin = carry_in;
         default: ;
      endcase
      add_sum  = {1'b0, a} + {1'b0, add_b} + {{DATA_WIDTH{1'b0}}, add_cin};
      sub_diff = {1'b0, sub_a} - {1'b0, sub_b} - {{DATA_WIDTH{1'b0}}, sub_bin};
      add_v    = (a[MSB] == add_b[MSB]) && (add_sum[MSB] != a[MSB]);
      sub_v    = (sub_a[MSB] != sub_b[MSB]) && (sub_diff[MSB] != sub_a[MSB]);
   end

   always_comb begin
      result    = '0;
      carry_out = 1'b0;
      overflow  = 1'b0;
      case (opcode)
         OP_ADD, OP_INC, OP_ADC: begin
            result    = add_sum[DATA_WIDTH-1:0];
            carry_out = add_sum[DATA_WIDTH];
            overflow  = add_v;
         end
         OP_SUB, OP_DEC, OP_NEG, OP_SBB: begin
            result    = sub_diff[DATA_WIDTH-1:0];
            carry_out = sub_diff[DATA_WIDTH];
            overflow  = sub_v;
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOT:  result = ~a;
         OP_SHL:  begin
            result    = {a[MSB-1:0], 1'b0};
            carry_out = a[MSB];
         end
         OP_SHR:  begin
            result    = {1'b0, a[MSB:1]};
            carry_out = a[0];
         end
         OP_SAR:  begin
            result    = {a[MSB], a[MSB:1]};
            carry_out = a[0];
         end
         OP_ROL:  begin
            result    = {a[MSB-1:0], a[MSB]};
            carry_out = a[MSB];
         end
         OP_ROR:  begin
            result    = {a[0], a[MSB:1]};
            carry_out = a[0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_top.sv
// Registered ALU: latency 1, one op per cycle; Z and P are derived from the new
// result before it is registered, and flag_C feeds back as ADC/SBB carry-in.
module alu_top
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int OPCODE_WIDTH = DEFAULT_OPCODE_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_p,
   input  logic [DATA_WIDTH-1:0]   A,
   input  logic [DATA_WIDTH-1:0]   B,
   input  logic [OPCODE_WIDTH-1:0] opcode,
   output logic [DATA_WIDTH-1:0]   result,
   output logic                    flag_C,
   output logic                    flag_Z,
   output logic                    flag_P,
   output logic                    flag_V
);

   logic [DATA_WIDTH-1:0] result_d, result_q;
   logic                  c_d, c_q;
   logic                  z_d, z_q;
   logic                  p_d, p_q;
   logic                  v_d, v_q;

   alu_datapath #(
      .DATA_WIDTH   (DATA_WIDTH),
      .OPCODE_WIDTH (OPCODE_WIDTH)
   ) u_datapath (
      .a         (A),
      .b         (B),
      .opcode    (opcode),
      .carry_in  (c_q),
      .result    (result_d),
      .carry_out (c_d),
      .overflow  (v_d)
   );

   always_comb begin
      z_d = (result_d == '0);
      p_d = ~^result_d;
   end

   always_ff @(posedge clk) begin
      if (rst_p) begin
         result_q <= '0;
         c_q      <= 1'b0;
         z_q      <= 1'b0;
         p_q      <= 1'b0;
         v_q      <= 1'b0;
      end else begin
         result_q <= result_d;
         c_q      <= c_d;
         z_q      <= z_d;
         p_q      <= p_d;
         v_q      <= v_d;
      end
   end

   assign result = result_q;
   assign flag_C = c_q;
   assign flag_Z = z_q;
   assign flag_P = p_q;
   assign flag_V = v_q;

endmodule

// File: tb/tb_alu_top.sv
// Directed bench for alu_top: each step pushes hand-derived expectations to a
// scoreboard that is popped and compared one cycle later, on the falling edge.
module tb_alu_top;
   import alu_pkg::*;

   typedef struct {
      string      tag;
      logic [7:0] r;
      logic       c;
      logic       z;
      logic       p;
      logic       v;
   } exp_t;

   logic       clk;
   logic       rst_p;
   logic [7:0] a_in;
   logic [7:0] b_in;
   logic [3:0] op_in;
   logic [7:0] result;
   logic       flag_C;
   logic       flag_Z;
   logic       flag_P;
   logic       flag_V;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   alu_top dut (
      .clk    (clk),
      .rst_p  (rst_p),
      .A      (a_in),
      .B      (b_in),
      .opcode (op_in),
      .result (result),
      .flag_C (flag_C),
      .flag_Z (flag_Z),
      .flag_P (flag_P),
      .flag_V (flag_V)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compares the oldest pending expectation against the registered outputs.
   task automatic checkOutput();
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         assert (result === e.r) else begin
            errors++;
            $error("[TB] FAIL %s result got %h expected %h", e.tag, result, e.r);
         end
         checks++;
         assert ({flag_C, flag_Z, flag_P, flag_V} === {e.c, e.z, e.p, e.v}) else begin
            errors++;
            $error("[TB] FAIL %s flags CZPV got %b%b%b%b expected %b%b%b%b", e.tag,
                   flag_C, flag_Z, flag_P, flag_V, e.c, e.z, e.p, e.v);
         end
      end
   endtask

   // On each falling edge: check last cycle's result, then drive the next step.
   task automatic applyStimulus(input string tag, input logic rst, input logic [3:0] op,
                                input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] er, input logic ec, input logic ev);
      exp_t e;
      @(negedge clk);
      checkOutput();
      rst_p = rst;
      op_in = op;
      a_in  = a;
      b_in  = b;
      e.tag = tag;
      e.r   = rst ? 8'h00 : er;
      e.c   = rst ? 1'b0 : ec;
      e.v   = rst ? 1'b0 : ev;
      e.z   = rst ? 1'b0 : (er == 8'h00);
      e.p   = rst ? 1'b0 : ~^er;
      sb.push_back(e);
   endtask

   initial begin
      rst_p = 1'b1;
      a_in  = 8'h00;
      b_in  = 8'h00;
      op_in = 4'h0;

      for (int i = 0; i < 3; i++)
         applyStimulus("reset", 1'b1, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
                       8'h00, 1'b0, 1'b0);

      // Opcode sweep with A=AA, B=05; ADC sees C=1 from NEG, SBB sees C=0 from ADC.
      applyStimulus("add",  1'b0, OP_ADD, 8'hAA, 8'h05, 8'hAF, 1'b0, 1'b0);
      applyStimulus("sub",  1'b0, OP_SUB, 8'hAA, 8'h05, 8'hA5, 1'b0, 1'b0);
      applyStimulus("inc",  1'b0, OP_INC, 8'hAA, 8'h05, 8'hAB, 1'b0, 1'b0);
      applyStimulus("dec",  1'b0, OP_DEC, 8'hAA, 8'h05, 8'hA9, 1'b0, 1'b0);
      applyStimulus("and",  1'b0, OP_AND, 8'hAA, 8'h05, 8'h00, 1'b0, 1'b0);
      applyStimulus("or",   1'b0, OP_OR,  8'hAA, 8'h05, 8'hAF, 1'b0, 1'b0);
      applyStimulus("xor",  1'b0, OP_XOR, 8'hAA, 8'h05, 8'hAF, 1'b0, 1'b0);
      applyStimulus("not",  1'b0, OP_NOT, 8'hAA, 8'h05, 8'h55, 1'b0, 1'b0);
      applyStimulus("shl",  1'b0, OP_SHL, 8'hAA, 8'h05, 8'h54, 1'b1, 1'b0);
      applyStimulus("shr",  1'b0, OP_SHR, 8'hAA, 8'h05, 8'h55, 1'b0, 1'b0);
      applyStimulus("sar",  1'b0, OP_SAR, 8'hAA, 8'h05, 8'hD5, 1'b0, 1'b0);
      applyStimulus("rol",  1'b0, OP_ROL, 8'hAA, 8'h05, 8'h55, 1'b1, 1'b0);
      applyStimulus("ror",  1'b0, OP_ROR, 8'hAA, 8'h05, 8'h55, 1'b0, 1'b0);
      applyStimulus("neg",  1'b0, OP_NEG, 8'hAA, 8'h05, 8'h56, 1'b1, 1'b0);
      applyStimulus("adc",  1'b0, OP_ADC, 8'hAA, 8'h05, 8'hB0, 1'b0, 1'b0);
      applyStimulus("sbb",  1'b0, OP_SBB, 8'hAA, 8'h05, 8'hA5, 1'b0, 1'b0);

      applyStimulus("inc_7f", 1'b0, OP_INC, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b1);
      applyStimulus("dec_00", 1'b0, OP_DEC, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0);
      applyStimulus("neg_80", 1'b0, OP_NEG, 8'h80, 8'h00, 8'h80, 1'b1, 1'b1);
      applyStimulus("add_ov", 1'b0, OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
      applyStimulus("sub_ov", 1'b0, OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

      applyStimulus("chain_add", 1'b0, OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
      applyStimulus("chain_adc", 1'b0, OP_ADC, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0);
      applyStimulus("chain_sub", 1'b0, OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
      applyStimulus("chain_sbb", 1'b0, OP_SBB, 8'h05, 8'h01, 8'h03, 1'b0, 1'b0);

      applyStimulus("mid_add",   1'b0, OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
      applyStimulus("mid_reset", 1'b1, OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0);
      applyStimulus("mid_adc",   1'b0, OP_ADC, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

      applyStimulus("sar_80", 1'b0, OP_SAR, 8'h80, 8'h00, 8'hC0, 1'b0, 1'b0);
      applyStimulus("shr_01", 1'b0, OP_SHR, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0);
      applyStimulus("rol_81", 1'b0, OP_ROL, 8'h81, 8'h00, 8'h03, 1'b1, 1'b0);
      applyStimulus("ror_01", 1'b0, OP_ROR, 8'h01, 8'h00, 8'h80, 1'b1, 1'b0);

      @(negedge clk);
      checkOutput();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
